// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding,
// counter sizing and the parameter-legality rule used at elaboration.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int dividend_w, input int divider_w,
                                   input int bits_per_cycle);
    bit bpc_ok;
    bpc_ok = (bits_per_cycle == 1) || (bits_per_cycle == 2) ||
             (bits_per_cycle == 4) || (bits_per_cycle == 8);
    return bpc_ok && (dividend_w % bits_per_cycle == 0) &&
           (divider_w <= dividend_w) && (divider_w > 0);
  endfunction

endpackage

// File: rtl/divider_step.sv
// Combinational restoring step: BITS_PER_CYCLE chained shift/compare/subtract
// stages, most significant dividend bit first.
module divider_step
  import divider_pkg::*;
#(
  parameter int DIVIDER_WIDTH  = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [DIVIDER_WIDTH:0]    rem_i,
  input  logic [BITS_PER_CYCLE-1:0] slice_i,
  input  logic [DIVIDER_WIDTH-1:0]  divisor_i,
  output logic [DIVIDER_WIDTH:0]    rem_o,
  output logic [BITS_PER_CYCLE-1:0] quot_o
);

  logic [DIVIDER_WIDTH:0] r;

  // NOTE: blocking assignments are deliberate here -- each stage must see the
  // previous stage's remainder within the same evaluation. Defaults up front
  // keep every output driven on every path, so no latch can be inferred.
  always_comb begin
    r      = rem_i;
    quot_o = '0;
    for (int j = BITS_PER_CYCLE - 1; j >= 0; j--) begin
      r = {r[DIVIDER_WIDTH-1:0], slice_i[j]};
      if (r >= {1'b0, divisor_i}) begin
        r         = r - {1'b0, divisor_i};
        quot_o[j] = 1'b1;
      end
    end
    rem_o = r;
  end

endmodule

// File: rtl/divider_iterative.sv
// Multi-cycle restoring divider, unsigned or signed (truncating) per operation,
// with valid/ready handshakes and divide-by-zero / signed-overflow flags.
module divider_iterative
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVIDER_WIDTH  = 8,
  parameter int BITS_PER_CYCLE = 2,
  parameter int SIGNED_EN      = 1
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic                      in_data_valid,
  output logic                      out_ready,
  input  logic                      in_signed,
  input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
  input  logic [DIVIDER_WIDTH-1:0]  in_divider,
  output logic                      out_data_valid,
  input  logic                      in_result_ready,
  output logic [DIVIDEND_WIDTH-1:0] out_quotient,
  output logic [DIVIDER_WIDTH-1:0]  out_remainder,
  output logic                      out_div_by_zero,
  output logic                      out_overflow
);

  localparam int DW    = DIVIDEND_WIDTH;
  localparam int VW    = DIVIDER_WIDTH;
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int ITER  = DW / BPC;
  localparam int CNT_W = (ITER > 1) ? clog2(ITER) : 1;

  if (!params_ok(DW, VW, BPC)) begin : g_bad_params
    $error("divider_iterative: illegal width / BITS_PER_CYCLE combination");
  end

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DW-1:0]     dvd_q;       // dividend magnitude shifts out, quotient shifts in
  logic [VW:0]       prem_q;
  logic [VW-1:0]     dvs_q;
  logic [VW-1:0]     dvd_lo_q;
  logic              neg_quot_q, neg_rem_q, zero_q, ovf_q;
  logic              valid_q, dz_q, ovf_out_q;
  logic [DW-1:0]     quot_q;
  logic [VW-1:0]     rem_q;

  logic              accept_d, sign_op_d, dvd_neg_d, dvs_neg_d, ovf_d;
  logic [DW-1:0]     dvd_mag_d, quot_fix_d;
  logic [VW-1:0]     dvs_mag_d, rem_mag_d, rem_fix_d;
  logic [VW:0]       prem_d;
  logic [BPC-1:0]    qbits_d;

  assign out_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & in_result_ready);
  assign accept_d  = in_data_valid & out_ready;

  always_comb begin
    sign_op_d = (SIGNED_EN != 0) & in_signed;
    dvd_neg_d = sign_op_d & in_dividend[DW-1];
    dvs_neg_d = sign_op_d & in_divider[VW-1];
    dvd_mag_d = dvd_neg_d ? -in_dividend : in_dividend;
    dvs_mag_d = dvs_neg_d ? -in_divider : in_divider;
    ovf_d     = sign_op_d & (in_dividend == {1'b1, {(DW-1){1'b0}}}) & (&in_divider);
  end

  divider_step #(
    .DIVIDER_WIDTH (VW),
    .BITS_PER_CYCLE(BPC)
  ) u_step (
    .rem_i    (prem_q),
    .slice_i  (dvd_q[DW-1 -: BPC]),
    .divisor_i(dvs_q),
    .rem_o    (prem_d),
    .quot_o   (qbits_d)
  );

  // Sign fixup and flag overrides; divide-by-zero outranks overflow.
  always_comb begin
    rem_mag_d  = prem_q[VW-1:0];
    quot_fix_d = neg_quot_q ? -dvd_q : dvd_q;
    rem_fix_d  = neg_rem_q ? -rem_mag_d : rem_mag_d;
    if (zero_q) begin
      quot_fix_d = '1;
      rem_fix_d  = dvd_lo_q;
    end else if (ovf_q) begin
      quot_fix_d = {1'b1, {(DW-1){1'b0}}};
      rem_fix_d  = '0;
    end
  end

  // NOTE: the datapath registers are reset along with the control state so
  // that an aborted operation leaves nothing stale on the outputs.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      prem_q     <= '0;
      dvs_q      <= '0;
      dvd_lo_q   <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_out_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else if (accept_d) begin
      state_q    <= ST_CALC;
      cnt_q      <= '0;
      dvd_q      <= dvd_mag_d;
      prem_q     <= '0;
      dvs_q      <= dvs_mag_d;
      dvd_lo_q   <= in_dividend[VW-1:0];
      neg_quot_q <= dvd_neg_d ^ dvs_neg_d;
      neg_rem_q  <= dvd_neg_d;
      zero_q     <= (in_divider == '0);
      ovf_q      <= ovf_d;
      valid_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_out_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CALC: begin
          prem_q <= prem_d;
          dvd_q  <= (dvd_q << BPC) | DW'(qbits_d);
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          quot_q    <= quot_fix_d;
          rem_q     <= rem_fix_d;
          dz_q      <= zero_q;
          ovf_out_q <= ovf_q & ~zero_q;
          valid_q   <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          if (in_result_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data_valid  = valid_q;
  assign out_quotient    = quot_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dz_q;
  assign out_overflow    = ovf_out_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench: directed cases plus randomized traffic compared
// cycle by cycle against an arithmetic reference model.
module tb_divider_iterative;

  localparam int DW   = 16;
  localparam int VW   = 8;
  localparam int BPC  = 2;
  localparam int ITER = DW / BPC;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic          ov;
  } res_t;

  logic          in_clk = 1'b0;
  logic          in_rst_n = 1'b0;
  logic          in_data_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic [DW-1:0] in_dividend = '0;
  logic [VW-1:0] in_divider = '0;
  logic          in_result_ready = 1'b1;
  logic          out_ready, out_data_valid, out_div_by_zero, out_overflow;
  logic [DW-1:0] out_quotient;
  logic [VW-1:0] out_remainder;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  int   lat = -1;
  bit   seen_valid = 1'b0;
  bit   rand_rr = 1'b0;

  divider_iterative #(
    .DIVIDEND_WIDTH(DW), .DIVIDER_WIDTH(VW), .BITS_PER_CYCLE(BPC), .SIGNED_EN(1)
  ) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_data_valid(in_data_valid),
    .out_ready(out_ready), .in_signed(in_signed), .in_dividend(in_dividend),
    .in_divider(in_divider), .out_data_valid(out_data_valid),
    .in_result_ready(in_result_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_div_by_zero(out_div_by_zero),
    .out_overflow(out_overflow)
  );

  initial forever #5 in_clk = ~in_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic (SV / and % truncate toward zero).
  function automatic res_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s);
    res_t   m;
    longint x, y, qq, rr;
    m = '0;
    if (b == '0) begin
      m.q  = '1;
      m.r  = a[VW-1:0];
      m.dz = 1'b1;
    end else if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      if (x == -(longint'(1) << (DW - 1)) && y == -1) begin
        m.q  = {1'b1, {(DW-1){1'b0}}};
        m.ov = 1'b1;
      end else begin
        qq  = x / y;
        rr  = x % y;
        m.q = qq[DW-1:0];
        m.r = rr[VW-1:0];
      end
    end else begin
      x   = longint'(a);
      y   = longint'(b);
      qq  = x / y;
      rr  = x % y;
      m.q = qq[DW-1:0];
      m.r = rr[VW-1:0];
    end
    return m;
  endfunction

  // Compare process: every cycle, outputs against the model's view.
  initial forever begin
    @(negedge in_clk);
    if (!in_rst_n) begin
      exp_q.delete();
      lat = -1;
    end else begin
      if (lat >= 0) lat++;
      if (out_data_valid) begin
        if (exp_q.size() == 0) begin
          check("no_spurious_valid", {31'd0, out_data_valid}, 32'd0);
        end else begin
          if (!seen_valid) check("latency", lat, ITER + 2);
          seen_valid = 1'b1;
          check("quotient",   out_quotient,    exp_q[0].q);
          check("remainder",  out_remainder,   exp_q[0].r);
          check("div_by_zero", out_div_by_zero, exp_q[0].dz);
          check("overflow",   out_overflow,    exp_q[0].ov);
        end
        check("ready_in_done", out_ready, in_result_ready);
      end else begin
        check("ready_state", out_ready, exp_q.size() == 0);
        if (exp_q.size() > 0 && lat >= ITER + 2) check("valid_missing", 0, 1);
      end
      if (out_data_valid && in_result_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_data_valid && out_ready) begin
        exp_q.push_back(model(in_dividend, in_divider, in_signed));
        lat        = 0;
        seen_valid = 1'b0;
      end
    end
  end

  // Random consumer back-pressure, only during the randomized phase.
  initial forever begin
    @(posedge in_clk);
    #1;
    if (rand_rr) in_result_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s);
    bit acc;
    int guard;
    in_dividend   = a;
    in_divider    = b;
    in_signed     = s;
    in_data_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge in_clk);
      acc = out_ready;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("accept_timeout", 0, 1);
    @(posedge in_clk);
    #1;
    in_data_valid = 1'b0;
    in_dividend   = DW'($urandom);
    in_divider    = VW'($urandom);
    in_signed     = 1'($urandom);
  endtask

  task automatic wait_consumed();
    int guard;
    guard = 0;
    do begin
      @(negedge in_clk);
      guard++;
    end while (!(out_data_valid && in_result_ready) && guard < 100);
    if (guard >= 100) check("result_timeout", 0, 1);
    @(posedge in_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_data_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, out_ready}, 32'd1);
    check({tag, "_quot"},  out_quotient, 32'd0);
    check({tag, "_rem"},   out_remainder, 32'd0);
    check({tag, "_flags"}, {30'd0, out_div_by_zero, out_overflow}, 32'd0);
  endtask

  initial begin
    res_t          m;
    logic [DW-1:0] hq;
    logic [VW-1:0] hr, b;
    logic [DW-1:0] a;
    logic          s;
    int            n, guard;

    // Pin the model to hand-computed results.
    m = model(16'd1000, 8'd7, 1'b0);    check("pin_1000_7", {m.q, m.r, m.dz, m.ov}, {16'd142, 8'd6, 2'b00});
    m = model(16'hFFF9, 8'h02, 1'b1);   check("pin_s_m7_2", {m.q, m.r, m.dz, m.ov}, {16'hFFFD, 8'hFF, 2'b00});
    m = model(16'hFFF9, 8'h02, 1'b0);   check("pin_u_fff9_2", {m.q, m.r, m.dz, m.ov}, {16'h7FFC, 8'h01, 2'b00});
    m = model(16'h1234, 8'h00, 1'b0);   check("pin_div0", {m.q, m.r, m.dz, m.ov}, {16'hFFFF, 8'h34, 2'b10});
    m = model(16'h8000, 8'hFF, 1'b1);   check("pin_ovf", {m.q, m.r, m.dz, m.ov}, {16'h8000, 8'h00, 2'b01});
    m = model(16'h8000, 8'h80, 1'b1);   check("pin_s_min_min", {m.q, m.r, m.dz, m.ov}, {16'h0100, 8'h00, 2'b00});
    m = model(16'hFFFF, 8'hFF, 1'b0);   check("pin_ffff_ff", {m.q, m.r, m.dz, m.ov}, {16'd257, 8'h00, 2'b00});

    repeat (3) @(posedge in_clk);
    @(negedge in_clk);
    check_reset_outputs("por");
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;

    // Directed cases; the compare process checks values and latency.
    send(16'd1000, 8'd7, 1'b0);     wait_consumed();
    send(16'hFFF9, 8'h02, 1'b1);    wait_consumed();
    send(16'hFFF9, 8'h02, 1'b0);    wait_consumed();
    send(16'h1234, 8'h00, 1'b0);    wait_consumed();
    send(16'h8000, 8'hFF, 1'b1);    wait_consumed();
    send(16'h8000, 8'h80, 1'b1);    wait_consumed();

    // Back-pressure: hold the result for 5 cycles, then consume and re-issue together.
    in_result_ready = 1'b0;
    send(16'd5000, 8'd13, 1'b0);
    guard = 0;
    do begin
      @(negedge in_clk);
      guard++;
    end while (!out_data_valid && guard < 50);
    check("bp_valid_seen", {31'd0, out_data_valid}, 32'd1);
    hq = out_quotient;
    hr = out_remainder;
    repeat (5) begin
      check("bp_ready_low", {31'd0, out_ready}, 32'd0);
      check("bp_hold", {out_quotient, out_remainder, out_data_valid}, {hq, hr, 1'b1});
      @(negedge in_clk);
    end
    @(posedge in_clk);
    #1;
    in_result_ready = 1'b1;
    send(16'hABCD, 8'h9A, 1'b1);
    wait_consumed();

    // Reset during the third CALC iteration.
    send(16'h7777, 8'h05, 1'b0);
    repeat (2) @(posedge in_clk);
    #1;
    in_rst_n = 1'b0;
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;
    @(negedge in_clk);
    check_reset_outputs("mid_rst");
    repeat (12) begin
      @(negedge in_clk);
      check("mid_rst_no_stale", {31'd0, out_data_valid}, 32'd0);
    end
    @(posedge in_clk);
    #1;
    send(16'hFFFF, 8'hFF, 1'b0);
    wait_consumed();

    // Randomized traffic with random consumer stalls and idle gaps.
    rand_rr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = DW'($urandom);
      b = VW'($urandom);
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 16'h8000; b = 8'hFF; s = 1'b1; end
        2: b = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'hFF;
        3: a = {1'b1, 15'($urandom_range(0, 3))};
        default: ;
      endcase
      send(a, b, s);
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge in_clk);
        #1;
      end
    end
    rand_rr         = 1'b0;
    in_result_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge in_clk);
      guard++;
    end
    check("drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
